// File: rtl/seq_arbiter.sv
// Round-robin arbiter that lends one shared serial pattern detector to two requesters:
// it clears the detector, shifts the winner's pattern in MSB first and returns the z history.
module seq_arbiter #(
  parameter int NBITS = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [NBITS-1:0] Data0,
  input  logic [NBITS-1:0] Data1,
  input  logic             z_in,
  output logic             w_out,
  output logic             FsmClr,
  output logic [1:0]       Gnt,
  output logic             Busy,
  output logic             Done0,
  output logic             Done1,
  output logic [NBITS-1:0] Result
);

  localparam int CW = $clog2(NBITS);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [NBITS-1:0] sreg;
  logic [NBITS-2:0] hist;
  logic             ptr;
  logic             any_req, win1, last;

  assign any_req = Req0 | Req1;
  // ptr holds the last requester served, so a tie goes to the other one
  assign win1    = Req1 & (~Req0 | ~ptr);
  assign last    = (cnt == CW'(NBITS-1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = CLEAR;
      CLEAR:   state_nx = SHIFT;
      SHIFT:   if (last) state_nx = REPORT;
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Detector is held cleared while idle as well as in CLEAR
  always_comb begin
    w_out  = 1'b0;
    FsmClr = 1'b0;
    Busy   = 1'b1;
    case (state)
      IDLE:    begin FsmClr = 1'b1; Busy = 1'b0; end
      CLEAR:   FsmClr = 1'b1;
      SHIFT:   w_out = sreg[NBITS-1];
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Gnt    <= 2'b00;
      Done0  <= 1'b0;
      Done1  <= 1'b0;
      Result <= '0;
      ptr    <= 1'b1;
      cnt    <= '0;
      sreg   <= '0;
      hist   <= '0;
    end else begin
      Done0 <= 1'b0;
      Done1 <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          Gnt  <= win1 ? 2'b10 : 2'b01;
          sreg <= win1 ? Data1 : Data0;
          hist <= '0;
          cnt  <= '0;
        end
        SHIFT: begin
          sreg <= sreg << 1;
          cnt  <= cnt + CW'(1);
          // z after bit k is visible during cycle k+1; cycle 0 shows the cleared state
          if (cnt != '0) hist <= (hist << 1) | (NBITS-1)'(z_in);
        end
        REPORT: begin
          Result <= {hist, z_in};
          Done0  <= Gnt[0];
          Done1  <= Gnt[1];
          ptr    <= Gnt[1];
          Gnt    <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule
